// File: rtl/ddr4_mrs_sequencer.sv
// DDR4 mode-register initialisation sequencer: MR3, MR6, MR5, MR4, MR2, MR1, MR0, ZQCL
// issued to every rank, with clamshell address/bank mirroring on selected ranks.
module ddr4_mrs_sequencer #(
   parameter int                   NUM_RANKS   = 2,
   parameter logic [NUM_RANKS-1:0] MIRROR_MASK = 2'b10,
   parameter int                   T_MOD       = 24,
   parameter int                   T_ZQINIT    = 1024
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [97:0]          mr_data_i,
   output logic                 cmd_valid_o,
   input  logic                 cmd_ready_i,
   output logic [NUM_RANKS-1:0] cmd_cs_n_o,
   output logic                 cmd_act_n_o,
   output logic [16:0]          cmd_adr_o,
   output logic [1:0]           cmd_ba_o,
   output logic                 cmd_bg_o,
   output logic                 busy_o,
   output logic                 done_o
);
   localparam int RANK_W = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1;
   localparam int T_MAX  = (T_MOD > T_ZQINIT) ? T_MOD : T_ZQINIT;
   localparam int CNT_W  = $clog2(T_MAX + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   typedef struct packed {
      logic [NUM_RANKS-1:0] cs_n;
      logic                 act_n;
      logic [16:0]          adr;
      logic [1:0]           ba;
      logic                 bg;
   } cmd_t;

   logic [1:0]        state_q, state_d;
   logic [2:0]        step_q, step_d;
   logic [RANK_W-1:0] rank_q, rank_d;
   logic              last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   cmd_t              cmd_q, cmd_d;

   function automatic cmd_t idle_cmd();
      cmd_t c;
      c.cs_n  = '1;
      c.act_n = 1'b1;
      c.adr   = '0;
      c.ba    = '0;
      c.bg    = 1'b0;
      return c;
   endfunction

   function automatic logic [2:0] mr_num(input logic [2:0] step);
      case (step)
         3'd0:    mr_num = 3'd3;
         3'd1:    mr_num = 3'd6;
         3'd2:    mr_num = 3'd5;
         3'd3:    mr_num = 3'd4;
         3'd4:    mr_num = 3'd2;
         3'd5:    mr_num = 3'd1;
         default: mr_num = 3'd0;
      endcase
   endfunction

   function automatic logic [16:0] mirror_adr(input logic [16:0] a);
      logic [16:0] b;
      b     = a;
      b[3]  = a[4];
      b[4]  = a[3];
      b[5]  = a[6];
      b[6]  = a[5];
      b[7]  = a[8];
      b[8]  = a[7];
      b[11] = a[13];
      b[13] = a[11];
      return b;
   endfunction

   // Step 7 is ZQCL; every other step is an MRS carrying its MR payload.
   function automatic cmd_t encode(input logic [2:0] step, input logic [RANK_W-1:0] rank,
                                   input logic [97:0] mr);
      cmd_t       c;
      logic [2:0] mrn;
      logic [6:0] base;
      c = idle_cmd();
      c.cs_n[rank] = 1'b0;
      mrn  = mr_num(step);
      base = 7'(14 * mrn);
      if (step == 3'd7) begin
         c.adr = 17'h18400;
      end else begin
         c.adr = {3'b000, mr[base +: 14]};
         c.ba  = mrn[1:0];
         c.bg  = mrn[2];
      end
      if (MIRROR_MASK[rank]) begin
         c.adr = mirror_adr(c.adr);
         c.ba  = {c.ba[0], c.ba[1]};
      end
      return c;
   endfunction

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      rank_d  = rank_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = done_q;
      cmd_d   = cmd_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d = S_ISSUE;
               step_d  = 3'd0;
               rank_d  = '0;
               last_d  = 1'b0;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               cmd_d   = encode(3'd0, '0, mr_data_i);
            end
         end
         S_ISSUE: begin
            if (cmd_ready_i) begin
               state_d = S_WAIT;
               valid_d = 1'b0;
               cmd_d   = idle_cmd();
               last_d  = (step_q == 3'd7) && (rank_q == RANK_W'(NUM_RANKS - 1));
               cnt_d   = last_d ? CNT_W'(T_ZQINIT - 1) : CNT_W'(T_MOD - 1);
               if (rank_q == RANK_W'(NUM_RANKS - 1)) begin
                  rank_d = '0;
                  if (!last_d) step_d = step_q + 3'd1;
               end else begin
                  rank_d = rank_q + RANK_W'(1);
               end
            end
         end
         default: begin
            // Terminal count of 1 makes the next command appear T_MOD cycles after acceptance.
            if (cnt_q == CNT_W'(1)) begin
               if (last_q) begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ISSUE;
                  valid_d = 1'b1;
                  cmd_d   = encode(step_q, rank_q, mr_data_i);
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         step_q  <= '0;
         rank_q  <= '0;
         last_q  <= 1'b0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cmd_q   <= idle_cmd();
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         rank_q  <= rank_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cmd_q   <= cmd_d;
      end
   end

   assign cmd_valid_o = valid_q;
   assign cmd_cs_n_o  = cmd_q.cs_n;
   assign cmd_act_n_o = cmd_q.act_n;
   assign cmd_adr_o   = cmd_q.adr;
   assign cmd_ba_o    = cmd_q.ba;
   assign cmd_bg_o    = cmd_q.bg;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
endmodule

// File: tb/tb_ddr4_mrs_sequencer.sv
// Bench for ddr4_mrs_sequencer: predicts every cycle of the command stream from the
// DDR4 init rules (step order, MR encoding, mirroring, tMOD/tZQinit spacing).
module tb_ddr4_mrs_sequencer;
   localparam int         NR    = 2;
   localparam logic [1:0] MMASK = 2'b10;
   localparam int         TMOD  = 24;
   localparam int         TZQ   = 1024;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          start_i = 1'b0;
   logic [97:0]   mr_data_i = '0;
   logic          cmd_valid_o;
   logic          cmd_ready_i = 1'b0;
   logic [NR-1:0] cmd_cs_n_o;
   logic          cmd_act_n_o;
   logic [16:0]   cmd_adr_o;
   logic [1:0]    cmd_ba_o;
   logic          cmd_bg_o;
   logic          busy_o;
   logic          done_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int mr_order[7] = '{3, 6, 5, 4, 2, 1, 0};

   always #5 clk_i = ~clk_i;

   ddr4_mrs_sequencer #(
      .NUM_RANKS(NR), .MIRROR_MASK(MMASK), .T_MOD(TMOD), .T_ZQINIT(TZQ)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mr_data_i(mr_data_i),
      .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_cs_n_o(cmd_cs_n_o),
      .cmd_act_n_o(cmd_act_n_o), .cmd_adr_o(cmd_adr_o), .cmd_ba_o(cmd_ba_o),
      .cmd_bg_o(cmd_bg_o), .busy_o(busy_o), .done_o(done_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, 32'(cmd_valid_o), 32'd0);
      check({tag, "_cs_n"},  32'(cmd_cs_n_o),  32'h3);
      check({tag, "_act_n"}, 32'(cmd_act_n_o), 32'd1);
      check({tag, "_adr"},   32'(cmd_adr_o),   32'd0);
      check({tag, "_ba"},    32'(cmd_ba_o),    32'd0);
      check({tag, "_bg"},    32'(cmd_bg_o),    32'd0);
   endtask

   task automatic check_stat(input string tag, input logic busy, input logic done);
      check({tag, "_busy"}, 32'(busy_o), 32'(busy));
      check({tag, "_done"}, 32'(done_o), 32'(done));
   endtask

   // Command k of the sequence: step k/NR, rank k%NR.
   function automatic void model(input int k, input logic [97:0] mr, output logic [1:0] cs,
                                 output logic [16:0] adr, output logic [1:0] ba,
                                 output logic bg);
      int          step;
      int          rank;
      int          mrn;
      logic [16:0] t;
      int          pa[4] = '{3, 5, 7, 11};
      int          pb[4] = '{4, 6, 8, 13};
      step = k / NR;
      rank = k % NR;
      cs = 2'b11;
      cs[rank] = 1'b0;
      if (step == 7) begin
         adr = 17'h18400;
         ba  = 2'b00;
         bg  = 1'b0;
      end else begin
         mrn = mr_order[step];
         adr = {3'b000, mr[14*mrn +: 14]};
         ba  = 2'(mrn % 4);
         bg  = 1'(mrn / 4);
         if (MMASK[rank]) begin
            t = adr;
            for (int p = 0; p < 4; p++) begin
               adr[pa[p]] = t[pb[p]];
               adr[pb[p]] = t[pa[p]];
            end
            ba = {ba[0], ba[1]};
         end
      end
   endfunction

   task automatic run_seq(input logic [97:0] mr, input int stall_max, input int first_stall,
                          input int poke);
      int          next_present;
      int          done_at;
      int          nstall;
      logic [1:0]  ecs;
      logic [16:0] eadr;
      logic [1:0]  eba;
      logic        ebg;
      mr_data_i = mr;
      start_i = 1'b1;
      cyc = 0;
      tick();
      start_i = 1'b0;
      next_present = 1;
      for (int k = 0; k < 8 * NR; k++) begin
         while (cyc < next_present) begin
            check_idle("gap");
            check_stat("gap", 1'b1, 1'b0);
            cmd_ready_i = 1'($urandom_range(0, 1));
            start_i = (cyc == poke);
            tick();
         end
         model(k, mr, ecs, eadr, eba, ebg);
         nstall = (k == 0) ? first_stall : int'($urandom_range(0, stall_max));
         for (int s = 0; s <= nstall; s++) begin
            check("cmd_valid", 32'(cmd_valid_o), 32'd1);
            check("cmd_cs_n",  32'(cmd_cs_n_o),  32'(ecs));
            check("cmd_act_n", 32'(cmd_act_n_o), 32'd1);
            check("cmd_adr",   32'(cmd_adr_o),   32'(eadr));
            check("cmd_ba",    32'(cmd_ba_o),    32'(eba));
            check("cmd_bg",    32'(cmd_bg_o),    32'(ebg));
            check_stat("cmd", 1'b1, 1'b0);
            cmd_ready_i = (s == nstall);
            start_i = (cyc == poke);
            tick();
         end
         next_present = (cyc - 1) + TMOD;
      end
      start_i = 1'b0;
      done_at = (cyc - 1) + TZQ;
      while (cyc < done_at) begin
         check_idle("zqwait");
         check_stat("zqwait", 1'b1, 1'b0);
         cmd_ready_i = 1'($urandom_range(0, 1));
         start_i = (cyc == poke);
         tick();
      end
      start_i = 1'b0;
      check_idle("done");
      check_stat("done", 1'b0, 1'b1);
   endtask

   initial begin
      logic [127:0] r;
      logic [97:0]  mr;

      rst_i = 1'b1;
      start_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
      start_i = 1'b0;
      check_idle("reset");
      check_stat("reset", 1'b0, 1'b0);

      // Full sequence, ready always high, MR1 = A3 only, stray start at cycle 100.
      r  = {$urandom, $urandom, $urandom, $urandom};
      mr = r[97:0];
      mr[27:14] = 14'h0008;
      run_seq(mr, 0, 0, 100);
      check("done_cycle", 32'(cyc), 32'd1385);

      // Restart from DONE with 10 cycles of backpressure on the first command.
      r  = {$urandom, $urandom, $urandom, $urandom};
      run_seq(r[97:0], 0, 10, -1);

      // Random backpressure throughout.
      r  = {$urandom, $urandom, $urandom, $urandom};
      run_seq(r[97:0], 4, 2, 200);

      // Reset during the third WAIT, with start asserted alongside reset.
      r = {$urandom, $urandom, $urandom, $urandom};
      mr_data_i = r[97:0];
      start_i = 1'b1;
      cyc = 0;
      tick();
      start_i = 1'b0;
      cmd_ready_i = 1'b1;
      while (cyc < 60) tick();
      check_stat("pre_rst", 1'b1, 1'b0);
      rst_i = 1'b1;
      start_i = 1'b1;
      tick();
      rst_i = 1'b0;
      start_i = 1'b0;
      check_idle("rst_mid");
      check_stat("rst_mid", 1'b0, 1'b0);
      tick();
      check_idle("rst_after");
      check_stat("rst_after", 1'b0, 1'b0);

      r  = {$urandom, $urandom, $urandom, $urandom};
      run_seq(r[97:0], 3, 0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
